// File: rtl/dcache_pkg.sv
// Data-cache package: FSM state type and geometry constants built from cache_defs.v.
`include "cache_defs.v"

package dcache_pkg;

    typedef enum logic [`DC_STATE_BITS-1:0] {
        IDLE  = `DC_ST_IDLE,
        FILL  = `DC_ST_FILL,
        WRITE = `DC_ST_WRITE
    } dc_state_e;

    localparam int unsigned LINE_WORDS  = `WORDS_PER_LINE;
    localparam int unsigned OFFSET_BITS = `DC_OFFSET_BITS;
    localparam int unsigned WORD_BITS   = `DC_WORD_BITS;

endpackage

// File: rtl/cache_defs.v
// Shared data-cache definitions: FSM state encodings, line geometry and address field widths.
`ifndef CACHE_DEFS_V
`define CACHE_DEFS_V

// FSM state encodings
`define DC_STATE_BITS 2
`define DC_ST_IDLE    2'd0
`define DC_ST_FILL    2'd1
`define DC_ST_WRITE   2'd2

// Line geometry: 32-bit words, four words per line
`define WORDS_PER_LINE 4
`define DC_WORD_BITS   32
`define DC_ADDR_BITS   32

// Address field widths: byte-in-word, word-in-line, and tag for a given index width
`define DC_BYTE_BITS   2
`define DC_OFFSET_BITS 2
`define DC_LINE_LSB    4
`define DC_TAG_BITS(ib) (`DC_ADDR_BITS - (ib) - `DC_LINE_LSB)

`endif

// File: rtl/dcache_data_ram.sv
// Data array of the cache: 2^INDEX_BITS lines x 4 words, combinational read, one word write.
module dcache_data_ram
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 5
) (
    input  logic                   i_clk,
    input  logic [INDEX_BITS-1:0]  i_rd_index,
    input  logic [OFFSET_BITS-1:0] i_rd_offset,
    output logic [WORD_BITS-1:0]   o_rd_data,
    input  logic                   i_wr_en,
    input  logic [INDEX_BITS-1:0]  i_wr_index,
    input  logic [OFFSET_BITS-1:0] i_wr_offset,
    input  logic [WORD_BITS-1:0]   i_wr_data
);

    localparam int DEPTH = (1 << INDEX_BITS) * LINE_WORDS;

    logic [WORD_BITS-1:0] r_mem [DEPTH];

    assign o_rd_data = r_mem[{i_rd_index, i_rd_offset}];

    // Word write port; contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_index, i_wr_offset}] <= i_wr_data;
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a one-word memory port.
// Optional build macro DCACHE_STATS_EN adds hit_count/miss_count read statistics.
`include "cache_defs.v"

module dcache
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS     = 5,
    parameter int WORDS_PER_LINE = `WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] EXT_ADDR,
    input  logic [31:0] EXT_MEM_IN,
    output logic [31:0] EXT_MEM_OUT,
    output logic        ext_cache_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
`ifdef DCACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = `DC_TAG_BITS(INDEX_BITS);

    dc_state_e r_state, w_state_next;

    logic [LINES-1:0]       r_valid;
    logic [TAG_BITS-1:0]    r_tag [LINES];
    logic [1:0]             r_fill_cnt;
    logic                   r_wr_done;
    logic                   r_mem_req;
    logic                   r_mem_we;
    logic [31:0]            r_mem_addr;
    logic [31:0]            r_mem_wdata;

    logic [TAG_BITS-1:0]    w_tag;
    logic [INDEX_BITS-1:0]  w_index;
    logic [1:0]             w_offset;
    logic [TAG_BITS-1:0]    w_fill_tag;
    logic [INDEX_BITS-1:0]  w_fill_index;
    logic                   w_hit;
    logic                   w_read_hit;
    logic [31:0]            w_rd_data;
    logic                   w_stall;
    logic                   w_start_fill;
    logic                   w_start_write;
    logic                   w_fill_ack;
    logic                   w_fill_last;
    logic                   w_write_ack;
    logic                   w_ram_we;
    logic [INDEX_BITS-1:0]  w_ram_index;
    logic [1:0]             w_ram_offset;
    logic [31:0]            w_ram_wdata;
    logic                   w_unused;

    assign w_tag    = EXT_ADDR[31:INDEX_BITS+4];
    assign w_index  = EXT_ADDR[INDEX_BITS+3:4];
    assign w_offset = EXT_ADDR[3:2];
    assign w_unused = ^EXT_ADDR[1:0];

    // The line being filled is taken from the held request address, not the live inputs
    assign w_fill_tag   = r_mem_addr[31:INDEX_BITS+4];
    assign w_fill_index = r_mem_addr[INDEX_BITS+3:4];

    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // A simultaneous read and write is a write, so it never returns load data
    assign w_read_hit = (r_state == IDLE) && read_en && !write_en && w_hit;

    assign EXT_MEM_OUT     = w_read_hit ? w_rd_data : 32'd0;
    assign ext_cache_stall = w_stall;
    assign mem_req         = r_mem_req;
    assign mem_we          = r_mem_we;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;

    // Next-state, stall and control strobes
    always_comb begin
        w_state_next  = r_state;
        w_stall       = 1'b1;
        w_start_fill  = 1'b0;
        w_start_write = 1'b0;
        w_fill_ack    = 1'b0;
        w_fill_last   = 1'b0;
        w_write_ack   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_stall = 1'b0;
                if (write_en) begin
                    // wr_done marks the cycle the pipeline is released from a finished store
                    if (!r_wr_done) begin
                        w_stall       = 1'b1;
                        w_start_write = 1'b1;
                        w_state_next  = WRITE;
                    end
                end else if (read_en && !w_hit) begin
                    w_stall      = 1'b1;
                    w_start_fill = 1'b1;
                    w_state_next = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    w_fill_ack = 1'b1;
                    if (int'(r_fill_cnt) == WORDS_PER_LINE - 1) begin
                        w_fill_last  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    w_write_ack  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Backing-memory request registers; held stable until the matching ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_fill_cnt  <= 2'd0;
        end else if (w_start_write) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {EXT_ADDR[31:2], 2'b00};
            r_mem_wdata <= EXT_MEM_IN;
        end else if (w_start_fill) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {EXT_ADDR[31:4], 4'b0000};
            r_fill_cnt  <= 2'd0;
        end else if (w_fill_ack) begin
            if (w_fill_last) begin
                r_mem_req  <= 1'b0;
                r_fill_cnt <= 2'd0;
            end else begin
                r_fill_cnt      <= r_fill_cnt + 2'd1;
                r_mem_addr[3:2] <= r_fill_cnt + 2'd1;
            end
        end else if (w_write_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end
    end

    // Valid bits and the one-cycle store-complete flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= '0;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= w_write_ack;
            // Invalidate at the start of a fill so an abandoned fill leaves the line invalid
            if (w_start_fill) begin
                r_valid[w_index] <= 1'b0;
            end else if (w_fill_last) begin
                r_valid[w_fill_index] <= 1'b1;
            end
        end
    end

    // Tag array written when a fill completes; not reset
    always_ff @(posedge clk) begin
        if (w_fill_last) begin
            r_tag[w_fill_index] <= w_fill_tag;
        end
    end

    // Data array write source: fill words, or store data on a write hit
    always_comb begin
        w_ram_we     = w_fill_ack || (w_write_ack && w_hit);
        w_ram_index  = w_fill_ack ? w_fill_index : w_index;
        w_ram_offset = w_fill_ack ? r_fill_cnt : w_offset;
        w_ram_wdata  = w_fill_ack ? mem_rdata : EXT_MEM_IN;
    end

    dcache_data_ram #(
        .INDEX_BITS (INDEX_BITS)
    ) u_data_ram (
        .i_clk       (clk),
        .i_rd_index  (w_index),
        .i_rd_offset (w_offset),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_ram_we),
        .i_wr_index  (w_ram_index),
        .i_wr_offset (w_ram_offset),
        .i_wr_data   (w_ram_wdata)
    );

`ifdef DCACHE_STATS_EN
    logic        r_fill_done;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Count each read at its first IDLE cycle; the hit that ends a fill is not a new request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill_done  <= 1'b0;
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            r_fill_done <= w_fill_last;
            if ((r_state == IDLE) && read_en && !write_en) begin
                if (!w_hit) begin
                    r_miss_count <= r_miss_count + 32'd1;
                end else if (!r_fill_done) begin
                    r_hit_count <= r_hit_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios then random loads/stores against a
// transaction-level model (line valid/tag table plus a flat reference memory).
module tb_dcache;

    localparam int IB    = 5;
    localparam int LINES = 32;
    localparam int MWORDS = 1024;

    logic        clk;
    logic        reset;
    logic        read_en;
    logic        write_en;
    logic [31:0] EXT_ADDR;
    logic [31:0] EXT_MEM_IN;
    logic [31:0] EXT_MEM_OUT;
    logic        ext_cache_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        resp_ack;
    logic        stray_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    assign mem_ack = resp_ack | stray_ack;

    dcache #(
        .INDEX_BITS (IB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .read_en         (read_en),
        .write_en        (write_en),
        .EXT_ADDR        (EXT_ADDR),
        .EXT_MEM_IN      (EXT_MEM_IN),
        .EXT_MEM_OUT     (EXT_MEM_OUT),
        .ext_cache_stall (ext_cache_stall),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
`ifdef DCACHE_STATS_EN
        .hit_count       (hit_count),
        .miss_count      (miss_count),
`endif
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Backing memory (driven by the responder) and the bench's expected memory image
    logic [31:0] bmem    [MWORDS];
    logic [31:0] ref_mem [MWORDS];
    // Line model: which tag each index currently holds
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    int unsigned ref_hits;
    int unsigned ref_misses;

    // Responder bookkeeping
    logic [31:0] rd_addr_q [$];
    int          n_wr_acks = 0;
    int          n_unstable = 0;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] addr);
        return (addr >> 2) % MWORDS;
    endfunction

    // Memory responder: acks each request after a random 1..3 cycle delay
    initial begin
        int lat;
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        lat = -1;
        req_addr = '0;
        req_wdata = '0;
        resp_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            resp_ack = 1'b0;
            if (!mem_req || !reset) begin
                lat = -1;
            end else if (lat < 0) begin
                lat = $urandom_range(0, 2);
                req_addr = mem_addr;
                req_wdata = mem_wdata;
            end else if (lat == 0) begin
                if (mem_addr !== req_addr || mem_wdata !== req_wdata) n_unstable++;
                if (mem_we) begin
                    bmem[widx(mem_addr)] = mem_wdata;
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                    n_wr_acks++;
                end else begin
                    mem_rdata = bmem[widx(mem_addr)];
                    rd_addr_q.push_back(mem_addr);
                end
                resp_ack = 1'b1;
                lat = -1;
            end else begin
                lat--;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        ref_hits = 0;
        ref_misses = 0;
    endtask

    task automatic do_idle();
        @(negedge clk);
        read_en = 1'b0;
        write_en = 1'b0;
        EXT_ADDR = $urandom;
        #1;
        check_eq("idle_stall", 32'(ext_cache_stall), 32'd0);
        check_eq("idle_out", EXT_MEM_OUT, 32'd0);
        check_eq("idle_req", 32'(mem_req), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr);
        int unsigned idx;
        int unsigned tag;
        int unsigned q0;
        int unsigned cyc;
        bit          exp_hit;
        logic [31:0] exp_data;
        logic [31:0] base;
        idx = (addr >> 4) % LINES;
        tag = addr >> (IB + 4);
        exp_hit = m_valid[idx] && (m_tag[idx] == tag);
        exp_data = ref_mem[widx(addr)];
        @(negedge clk);
        read_en = 1'b1;
        write_en = 1'b0;
        EXT_ADDR = addr;
        EXT_MEM_IN = $urandom;
        #1;
        if (exp_hit) begin
            ref_hits++;
            check_eq("hit_stall", 32'(ext_cache_stall), 32'd0);
            check_eq("hit_no_req", 32'(mem_req), 32'd0);
            check_eq("hit_data", EXT_MEM_OUT, exp_data);
        end else begin
            ref_misses++;
            q0 = rd_addr_q.size();
            check_eq("miss_stall", 32'(ext_cache_stall), 32'd1);
            check_eq("miss_out_zero", EXT_MEM_OUT, 32'd0);
            cyc = 0;
            while (ext_cache_stall === 1'b1 && cyc < 200) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            check_eq("fill_timeout", 32'(cyc >= 200), 32'd0);
            check_eq("fill_words", rd_addr_q.size() - q0, 32'd4);
            base = addr & ~32'hF;
            for (int k = 0; k < 4; k++) begin
                if (q0 + k < rd_addr_q.size())
                    check_eq("fill_addr", rd_addr_q[q0 + k], base + 32'(4 * k));
            end
            check_eq("fill_release", 32'(ext_cache_stall), 32'd0);
            check_eq("fill_data", EXT_MEM_OUT, exp_data);
            m_valid[idx] = 1'b1;
            m_tag[idx] = tag;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        int unsigned w0;
        int unsigned r0;
        int unsigned cyc;
        @(negedge clk);
        write_en = 1'b1;
        read_en = 1'($urandom_range(0, 1));
        EXT_ADDR = addr;
        EXT_MEM_IN = data;
        #1;
        w0 = n_wr_acks;
        r0 = rd_addr_q.size();
        check_eq("wr_stall", 32'(ext_cache_stall), 32'd1);
        check_eq("wr_out_zero", EXT_MEM_OUT, 32'd0);
        cyc = 0;
        while (ext_cache_stall === 1'b1 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_eq("wr_timeout", 32'(cyc >= 200), 32'd0);
        check_eq("wr_count", n_wr_acks - w0, 32'd1);
        check_eq("wr_addr", last_wr_addr, addr & ~32'h3);
        check_eq("wr_data", last_wr_data, data);
        check_eq("wr_no_alloc", rd_addr_q.size() - r0, 32'd0);
        check_eq("wr_done_release", 32'(ext_cache_stall), 32'd0);
        ref_mem[widx(addr)] = data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        int unsigned q0;
        int unsigned cyc;
        int unsigned op;

        for (int i = 0; i < MWORDS; i++) begin
            bmem[i] = 32'hC0DE0000 ^ (i * 32'h9E37);
            ref_mem[i] = bmem[i];
        end
        for (int k = 0; k < 4; k++) begin
            bmem[64 + k] = 32'hA0 + k;
            ref_mem[64 + k] = 32'hA0 + k;
        end
        model_reset();

        reset = 1'b0;
        read_en = 1'b0;
        write_en = 1'b0;
        EXT_ADDR = '0;
        EXT_MEM_IN = '0;
        stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_stall", 32'(ext_cache_stall), 32'd0);
        check_eq("rst_out", EXT_MEM_OUT, 32'd0);
`ifdef DCACHE_STATS_EN
        check_eq("rst_hits", hit_count, 32'd0);
        check_eq("rst_misses", miss_count, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        do_idle();

        // Cold read, immediate hit, write hits (back to back), read-back
        do_read(32'h104);
        do_read(32'h10C);
        do_write(32'h108, 32'hDEADBEEF);
        do_write(32'h108, 32'hDEADBEEF);
        do_read(32'h108);
        check_eq("readback_108", EXT_MEM_OUT, 32'hDEADBEEF);

        // Write miss is not allocated; same-index conflict refills
        do_write(32'h304, 32'h12345678);
        do_read(32'h304);
        do_read(32'h104);
        do_read(32'h304);

        // Reset after the 2nd ack of a fill of 0x100
        @(negedge clk);
        read_en = 1'b1;
        write_en = 1'b0;
        EXT_ADDR = 32'h100;
        q0 = rd_addr_q.size();
        cyc = 0;
        while (rd_addr_q.size() - q0 < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("midfill_timeout", 32'(cyc >= 200), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("midfill_req", 32'(mem_req), 32'd0);
        check_eq("midfill_addr", mem_addr, 32'd0);
        read_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // A stray ack in IDLE must not start anything
        @(negedge clk);
        stray_ack = 1'b1;
        #1;
        check_eq("stray_stall", 32'(ext_cache_stall), 32'd0);
        @(negedge clk);
        stray_ack = 1'b0;
        #1;
        check_eq("stray_req", 32'(mem_req), 32'd0);

        do_read(32'h100);
        do_read(32'h104);
        do_read(32'h108);
        do_read(32'h10C);
`ifdef DCACHE_STATS_EN
        check_eq("stats_hits", hit_count, 32'd3);
        check_eq("stats_misses", miss_count, 32'd1);
`endif

        // Random traffic over three tags sharing four indices
        for (int n = 0; n < 250; n++) begin
            addr = 32'($urandom_range(0, 2) * 512 + $urandom_range(0, 3) * 16
                       + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
            op = $urandom_range(0, 9);
            if (op < 6) do_read(addr);
            else if (op < 9) do_write(addr, $urandom);
            else do_idle();
        end
        do_idle();
        check_eq("req_stable", n_unstable, 32'd0);
`ifdef DCACHE_STATS_EN
        check_eq("final_hits", hit_count, ref_hits);
        check_eq("final_misses", miss_count, ref_misses);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 5, meaning log2 of the line count (32 lines).
REQ-002 SHALL have parameter WORDS_PER_LINE, fixed at 4, meaning 32-bit words per line; the offset is EXT_ADDR[3:2].
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have these ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- read_en  in  1  load request from the MEM stage
- write_en  in  1  store request from the MEM stage
- EXT_ADDR  in  32  byte address; bits [1:0] are ignored
- EXT_MEM_IN  in  32  store data
- EXT_MEM_OUT  out  32  load data
- ext_cache_stall  out  1  pipeline hold
- mem_req  out  1  backing-memory request
- mem_we  out  1  backing-memory write
- mem_addr  out  32  word-aligned backing-memory address
- mem_wdata  out  32  backing-memory write data
- mem_rdata  in  32  backing-memory read data
- mem_ack  in  1  one-word completion strobe

Function
REQ-005 SHALL be direct-mapped, write-through, no-write-allocate.
REQ-006 SHALL split the address as tag = EXT_ADDR[31:INDEX_BITS+4], index = EXT_ADDR[INDEX_BITS+3:4], offset = EXT_ADDR[3:2].
REQ-007 SHALL define a hit as the line at the index being valid and its stored tag equal to the address tag.
REQ-008 SHALL implement FSM states IDLE, FILL and WRITE.
REQ-009 SHALL, for a read hit in IDLE, drive EXT_MEM_OUT combinationally in the same cycle, with ext_cache_stall=0 and zero added latency.
REQ-010 SHALL, for a read miss in IDLE:
- assert ext_cache_stall combinationally in the same cycle;
- clear the line's valid bit;
- move to FILL.
REQ-011 SHALL, in FILL:
- fetch words 0..3 in order, with mem_req=1, mem_we=0, mem_addr={tag,index,word,2'b00};
- hold each address until mem_ack, then write that word into the line;
- on the 4th ack, set valid, write the tag and return to IDLE.
REQ-012 SHALL, for write_en in IDLE with wr_done=0:
- assert ext_cache_stall;
- move to WRITE with mem_req=1, mem_we=1, mem_addr={EXT_ADDR[31:2],2'b00}, mem_wdata=EXT_MEM_IN.
REQ-013 SHALL, on mem_ack in WRITE:
- update the cached word if the access hits (a miss is not allocated);
- set wr_done=1 for exactly one cycle;
- return to IDLE.
REQ-014 SHALL drive ext_cache_stall=1 whenever the state is not IDLE.
REQ-015 SHALL, in IDLE, drive ext_cache_stall=0 for a read hit, for a write with wr_done=1, and when neither request is asserted.
REQ-016 SHALL treat read_en and write_en asserted together as a write.
REQ-017 SHALL ignore mem_ack while in IDLE.
REQ-018 SHALL hold mem_req, mem_addr and mem_wdata stable until mem_ack; mem_ack may arrive in the cycle after mem_req rises at the earliest.
REQ-019 SHALL rely on the MEM stage holding read_en, write_en, EXT_ADDR and EXT_MEM_IN stable while ext_cache_stall=1.
REQ-020 SHALL drive EXT_MEM_OUT=0 when there is no read hit.

Reset
REQ-021 SHALL, while reset=0, regardless of the current state:
- clear all valid bits;
- set FSM=IDLE, wr_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
- clear the fill word counter.
REQ-022 SHALL abandon an in-flight fill or write on reset, leave that line invalid, and ignore any later mem_ack until a new request is issued.
REQ-023 SHALL NOT reset the tag and data arrays.

Configuration
REQ-024 SHALL, with macro DCACHE_STATS_EN defined:
- add outputs hit_count[31:0] and miss_count[31:0];
- increment them once per read hit and once per read miss respectively, counting each at the first cycle of the request in IDLE (a miss is not recounted as a hit when it resolves);
- let both counters wrap at 2^32 and reset to 0.
REQ-025 SHALL, without DCACHE_STATS_EN, have neither those ports nor the counter logic.

Structure
REQ-026 SHALL place the state encodings, the WORDS_PER_LINE constant and the field-width macros in the shared include file cache_defs.v.
REQ-027 SHALL instantiate one sub-module, dcache_data_ram: a 2^INDEX_BITS x 4 x 32-bit array with a combinational read port and one synchronous word-write port.

Verification
REQ-028 SHALL cover a cold read: read_en=1, EXT_ADDR=0x00000104, memory word at 0x100+4k holds 0xA0+k -> stall for 4 acks, then EXT_MEM_OUT=0xA1 with stall=0.
REQ-029 SHALL cover a read hit: a read of 0x0000010C immediately after the cold read -> EXT_MEM_OUT=0xA3, stall=0 in the same cycle, no mem_req.
REQ-030 SHALL cover a write hit: write 0xDEADBEEF to 0x00000108 -> mem_we=1 with mem_addr=0x108; after ack, stall=0 for one cycle; a subsequent read of 0x108 returns 0xDEADBEEF as a hit.
REQ-031 SHALL cover a write miss plus conflict: write to 0x00000304 -> no fill; then a read of 0x304 misses, and a read of 0x104 (same index, other tag) misses and refills.
REQ-032 SHALL cover reset mid-fill: reset=0 after the 2nd ack of a fill of 0x100 -> mem_req=0 immediately; after release, a read of 0x100 misses and performs a full 4-word fill.
REQ-033 SHALL cover statistics (with DCACHE_STATS_EN): the sequence 0x100 miss, then 0x104, 0x108, 0x10C -> hit_count=3, miss_count=1.
